aqed_fifo_read_monitor: RTL and testbench

Read-side A-QED consumer and checker for the memory core in FIFO mode (mode 1). It drives the FIFO read enable under a formal-tool-controlled stall input and counts accepted output words. It captures the output word at the write indices the write-side tracker tagged as "original" and "duplicate", then reports the self-consistency result on qed_done/qed_check. It sits between the DUT read port and the formal property layer, opposite the write-side input tracker.

---
 rtl/aqed_fifo_read_monitor_if.sv | 11 +
 rtl/aqed_fifo_read_monitor.sv | 188 ++++++++++++++++++
 tb/tb_aqed_fifo_read_monitor.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/aqed_fifo_read_monitor_if.sv
// rtl/aqed_fifo_read_monitor_if.sv - FIFO read port between the memory core and the A-QED read monitor
interface aqed_fifo_read_monitor_if #(
  parameter int DATA_W = 16
) ();
  logic              ren_out;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;

  modport master (output ren_out, input valid_in, input data_in);
  modport slave  (input ren_out, output valid_in, output data_in);
endinterface

// File: rtl/aqed_fifo_read_monitor.sv
// rtl/aqed_fifo_read_monitor.sv - A-QED FIFO read-side consumer: counts accepted reads,
// captures the original and duplicate words by write index and reports self-consistency.
module aqed_fifo_read_monitor #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 17
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_en,
  input  logic                          stall_in,
  input  logic                          orig_idx_valid,
  input  logic [IDX_W-1:0]              orig_idx,
  input  logic                          dup_idx_valid,
  input  logic [IDX_W-1:0]              dup_idx,
  aqed_fifo_read_monitor_if.master      rd,
  output logic [IDX_W-1:0]              rd_count,
  output logic                          orig_done,
  output logic                          qed_done,
  output logic                          qed_check,
  output logic                          proto_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ORIG,
    S_DUP_IDX,
    S_WAIT_DUP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              ren_d1_q, ren_d1_d;
  logic [IDX_W-1:0]  rd_count_q, rd_count_d;
  logic              orig_done_q, orig_done_d;
  logic              qed_done_q, qed_done_d;
  logic              qed_check_q, qed_check_d;
  logic              proto_err_q, proto_err_d;
  logic [DATA_W-1:0] orig_data_q, orig_data_d;
  logic [IDX_W-1:0]  orig_idx_q, orig_idx_d;
  logic              orig_known_q, orig_known_d;
  logic [IDX_W-1:0]  dup_idx_q, dup_idx_d;
  logic              dup_known_q, dup_known_d;

  logic              ren;
  logic              accept;
  logic              orig_first;
  logic              dup_first;
  logic              orig_seen;
  logic [IDX_W-1:0]  orig_eff;
  logic [IDX_W-1:0]  dup_eff;
  logic              orig_hit;
  logic              dup_hit;
  logic              err_now;

  // Read request is combinational so it reacts to stall_in within the cycle.
  assign ren        = ~stall_in & ~qed_done_q & ~proto_err_q;
  assign rd.ren_out = ren;

  assign rd_count  = rd_count_q;
  assign orig_done = orig_done_q;
  assign qed_done  = qed_done_q;
  assign qed_check = qed_check_q;
  assign proto_err = proto_err_q;

  always_comb begin
    state_d      = state_q;
    ren_d1_d     = ren_d1_q;
    rd_count_d   = rd_count_q;
    orig_done_d  = orig_done_q;
    qed_done_d   = qed_done_q;
    qed_check_d  = qed_check_q;
    proto_err_d  = proto_err_q;
    orig_data_d  = orig_data_q;
    orig_idx_d   = orig_idx_q;
    orig_known_d = orig_known_q;
    dup_idx_d    = dup_idx_q;
    dup_known_d  = dup_known_q;

    accept     = clk_en & ren_d1_q & rd.valid_in;
    orig_first = orig_idx_valid & ~orig_known_q;
    dup_first  = dup_idx_valid & ~dup_known_q;
    orig_seen  = orig_known_q | orig_idx_valid;
    // Unregistered indices bypass straight into the match so a same-cycle accept is not lost.
    orig_eff   = orig_known_q ? orig_idx_q : orig_idx;
    dup_eff    = dup_known_q ? dup_idx_q : dup_idx;
    orig_hit   = accept & (rd_count_q == orig_eff);
    dup_hit    = accept & (rd_count_q == dup_eff);

    err_now = (dup_first & (~orig_seen | (dup_idx <= orig_eff)))
            | (orig_idx_valid & orig_known_q & (orig_idx != orig_idx_q))
            | (orig_first & (rd_count_q > orig_idx))
            | (dup_first & (state_q == S_DUP_IDX) & (rd_count_q > dup_idx));

    if (clk_en) begin
      ren_d1_d = ren;
      if (accept && (rd_count_q != '1)) begin
        rd_count_d = rd_count_q + 1'b1;
      end
      if (orig_first) begin
        orig_idx_d   = orig_idx;
        orig_known_d = 1'b1;
      end
      if (dup_first) begin
        dup_idx_d   = dup_idx;
        dup_known_d = 1'b1;
      end
      if (err_now) begin
        proto_err_d = 1'b1;
      end

      if (!err_now && !proto_err_q) begin
        case (state_q)
          S_IDLE: begin
            if (orig_idx_valid) begin
              state_d = S_WAIT_ORIG;
              if (orig_hit) begin
                orig_data_d = rd.data_in;
                orig_done_d = 1'b1;
                state_d     = dup_known_d ? S_WAIT_DUP : S_DUP_IDX;
              end
            end
          end
          S_WAIT_ORIG: begin
            if (orig_hit) begin
              orig_data_d = rd.data_in;
              orig_done_d = 1'b1;
              state_d     = dup_known_d ? S_WAIT_DUP : S_DUP_IDX;
            end
          end
          S_DUP_IDX: begin
            if (dup_idx_valid) begin
              state_d = S_WAIT_DUP;
              if (dup_hit) begin
                qed_done_d  = 1'b1;
                qed_check_d = (rd.data_in == orig_data_q);
                state_d     = S_DONE;
              end
            end
          end
          S_WAIT_DUP: begin
            if (dup_hit) begin
              qed_done_d  = 1'b1;
              qed_check_d = (rd.data_in == orig_data_q);
              state_d     = S_DONE;
            end
          end
          S_DONE: begin
            state_d = S_DONE;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ren_d1_q     <= 1'b0;
      rd_count_q   <= '0;
      orig_done_q  <= 1'b0;
      qed_done_q   <= 1'b0;
      qed_check_q  <= 1'b0;
      proto_err_q  <= 1'b0;
      orig_data_q  <= '0;
      orig_idx_q   <= '0;
      orig_known_q <= 1'b0;
      dup_idx_q    <= '0;
      dup_known_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ren_d1_q     <= ren_d1_d;
      rd_count_q   <= rd_count_d;
      orig_done_q  <= orig_done_d;
      qed_done_q   <= qed_done_d;
      qed_check_q  <= qed_check_d;
      proto_err_q  <= proto_err_d;
      orig_data_q  <= orig_data_d;
      orig_idx_q   <= orig_idx_d;
      orig_known_q <= orig_known_d;
      dup_idx_q    <= dup_idx_d;
      dup_known_q  <= dup_known_d;
    end
  end

endmodule

// File: tb/tb_aqed_fifo_read_monitor.sv
// tb/tb_aqed_fifo_read_monitor.sv - directed vector bench for aqed_fifo_read_monitor
module tb_aqed_fifo_read_monitor;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             clk_en;
  logic             stall_in;
  logic             orig_idx_valid;
  logic [IDX_W-1:0] orig_idx;
  logic             dup_idx_valid;
  logic [IDX_W-1:0] dup_idx;
  logic [IDX_W-1:0] rd_count;
  logic             orig_done;
  logic             qed_done;
  logic             qed_check;
  logic             proto_err;

  aqed_fifo_read_monitor_if #(.DATA_W(DATA_W)) bus ();

  aqed_fifo_read_monitor #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .stall_in       (stall_in),
    .orig_idx_valid (orig_idx_valid),
    .orig_idx       (orig_idx),
    .dup_idx_valid  (dup_idx_valid),
    .dup_idx        (dup_idx),
    .rd             (bus.master),
    .rd_count       (rd_count),
    .orig_done      (orig_done),
    .qed_done       (qed_done),
    .qed_check      (qed_check),
    .proto_err      (proto_err)
  );

  typedef struct {
    int rst, ce, stall, ov, oi, dv, di, pat;
    int ren, rd, od, qd, qc, pe;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: one-cycle read latency, gated by clk_en like the real core.
  logic              fifo_valid = 1'b0;
  logic [DATA_W-1:0] fifo_data  = '0;
  int                fifo_ptr   = 0;

  function automatic logic [DATA_W-1:0] fifo_word(input int pat, input int idx);
    case (pat)
      0:       return (idx == 2 || idx == 5) ? 16'hABCD : 16'(10 + idx);
      1:       return (idx == 2) ? 16'hABCD : (idx == 5) ? 16'h1234 : 16'(10 + idx);
      default: return (idx < 2) ? 16'h5A5A : 16'(10 + idx);
    endcase
  endfunction

  function automatic vec_t mk(input int rst, ce, stall, ov, oi, dv, di, pat,
                              input int ren, rd, od, qd, qc, pe);
    vec_t v;
    v.rst = rst; v.ce = ce; v.stall = stall; v.ov = ov; v.oi = oi;
    v.dv = dv; v.di = di; v.pat = pat;
    v.ren = ren; v.rd = rd; v.od = od; v.qd = qd; v.qc = qc; v.pe = pe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int rst, ce, stall, ov, oi, dv, di, pat, output logic ren_s);
    reset          = (rst != 0);
    clk_en         = (ce != 0);
    stall_in       = (stall != 0);
    orig_idx_valid = (ov != 0);
    orig_idx       = IDX_W'(oi);
    dup_idx_valid  = (dv != 0);
    dup_idx        = IDX_W'(di);
    bus.valid_in   = fifo_valid;
    bus.data_in    = fifo_data;
    #3;
    ren_s = bus.ren_out;
    @(posedge clk);
    if (rst != 0) begin
      fifo_valid = 1'b0;
      fifo_ptr   = 0;
    end else if (ce != 0) begin
      fifo_valid = ren_s;
      if (ren_s) begin
        fifo_data = fifo_word(pat, fifo_ptr);
        fifo_ptr++;
      end
    end
    #1;
  endtask

  function automatic vec_t rst_row(input int pre_ren);
    return mk(1, 1, 0, 0, 0, 0, 0, 0, pre_ren, 0, 0, 0, 0, 0);
  endfunction

  // orig at 2, dup at 5; captures after reads 2 and 5, one in-flight word lands after qed_done.
  task automatic add_basic(input int pat, input int qc);
    vecs.push_back(mk(0, 1, 0, 1, 2, 0, 0, pat, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 5, pat, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, pat, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, pat, 1, 3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, pat, 1, 4, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, pat, 1, 5, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, pat, 1, 6, 1, 1, qc, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, pat, 0, 7, 1, 1, qc, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, pat, 0, 7, 1, 1, qc, 0));
  endtask

  initial begin
    logic ren_s;
    int   cnt;
    logic rend1_m;
    logic ren_m;
    logic acc;
    logic ce_i;
    logic st_i;

    step(1, 1, 0, 0, 0, 0, 0, 0, ren_s);
    step(1, 1, 0, 0, 0, 0, 0, 0, ren_s);
    chk("reset rd_count", 32'(rd_count), 32'd0);
    chk("reset orig_done", 32'(orig_done), 32'd0);
    chk("reset qed_done", 32'(qed_done), 32'd0);
    chk("reset qed_check", 32'(qed_check), 32'd0);
    chk("reset proto_err", 32'(proto_err), 32'd0);
    stall_in = 1'b1;
    #1 chk("reset ren_out stall=1", 32'(bus.ren_out), 32'd0);
    stall_in = 1'b0;
    #1 chk("reset ren_out stall=0", 32'(bus.ren_out), 32'd1);

    // basic match, then mismatch
    add_basic(0, 1);
    vecs.push_back(rst_row(0));
    add_basic(1, 0);
    // bypass: orig index 0 arrives with the first accept, dup index 1 with the second
    vecs.push_back(rst_row(0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 2, 1, 2, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 3, 1, 1, 1, 0));
    // dup index below orig index
    vecs.push_back(rst_row(0));
    vecs.push_back(mk(0, 1, 0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1));
    // dup index before any orig index
    vecs.push_back(rst_row(0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 4, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    // reset while waiting for the duplicate, then a clean rerun
    vecs.push_back(rst_row(0));
    vecs.push_back(mk(0, 1, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 5, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0));
    vecs.push_back(rst_row(1));
    add_basic(0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ce, vecs[i].stall, vecs[i].ov, vecs[i].oi,
           vecs[i].dv, vecs[i].di, vecs[i].pat, ren_s);
      chk($sformatf("row%0d ren_out", i), 32'(ren_s), 32'(vecs[i].ren));
      chk($sformatf("row%0d rd_count", i), 32'(rd_count), 32'(vecs[i].rd));
      chk($sformatf("row%0d orig_done", i), 32'(orig_done), 32'(vecs[i].od));
      chk($sformatf("row%0d qed_done", i), 32'(qed_done), 32'(vecs[i].qd));
      chk($sformatf("row%0d qed_check", i), 32'(qed_check), 32'(vecs[i].qc));
      chk($sformatf("row%0d proto_err", i), 32'(proto_err), 32'(vecs[i].pe));
    end

    // stall_in and clk_en dropped on alternating odd cycles
    step(1, 1, 0, 0, 0, 0, 0, 0, ren_s);
    cnt     = 0;
    rend1_m = 1'b0;
    for (int i = 0; i < 48; i++) begin
      ce_i  = (i % 4) != 3;
      st_i  = (i % 4) == 1;
      ren_m = !st_i && (cnt < 6);
      acc   = ce_i && rend1_m && fifo_valid;
      step(0, int'(ce_i), int'(st_i), int'(i == 0), 2, int'(i == 1), 5, 0, ren_s);
      if (acc) cnt++;
      if (ce_i) rend1_m = ren_m;
      chk($sformatf("il%0d ren_out", i), 32'(ren_s), 32'(ren_m));
      chk($sformatf("il%0d rd_count", i), 32'(rd_count), 32'(cnt));
      chk($sformatf("il%0d orig_done", i), 32'(orig_done), 32'(cnt >= 3));
      chk($sformatf("il%0d qed_done", i), 32'(qed_done), 32'(cnt >= 6));
    end
    chk("interleave qed_check", 32'(qed_check), 32'd1);
    chk("interleave proto_err", 32'(proto_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
